// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, addresses the
// combinational ROM, and queues fetched words (2 entries) toward decode.
// Control events (halt > trap > uret > redirect) flush the queue and retarget
// the PC; a nested trap is fatal and parks the block in HALT.
module fetch_ctrl #(
  parameter int unsigned         PC_W     = 16,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] im_pc,
  input  logic [31:0]     im_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            trap,
  input  logic [PC_W-1:0] trap_vec,
  input  logic            uret,
  input  logic [PC_W-1:0] ret_pc,
  input  logic            halt,
  output logic            in_handler,
  output logic            halted,
  output logic            fault
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      count_q, count_d;
  logic            in_handler_q, in_handler_d;
  logic            fault_q, fault_d;

  // Queue storage; entry 0 is always the head.
  logic [PC_W-1:0] q_pc   [2];
  logic [31:0]     q_inst [2];

  logic            pop;
  logic            push;
  logic            flush;
  logic            push_idx;

  assign pop       = (count_q != 2'd0) && out_ready;
  assign im_pc     = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = q_pc[0];
  assign out_instr = q_inst[0];
  assign in_handler = in_handler_q;
  assign fault     = fault_q;
  assign halted    = (state_q == HALT);

  // Push lands after the surviving entries: slot 1 if one entry remains
  // after this cycle's pop, slot 0 otherwise.
  assign push_idx = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

  // Next-state, event arbitration and fetch decision.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    in_handler_d = in_handler_q;
    fault_d      = fault_q;
    flush        = 1'b0;
    push         = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALT;
          flush   = 1'b1;
        end else if (trap) begin
          flush = 1'b1;
          if (in_handler_q) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d         = trap_vec & ALIGN_MASK;
            in_handler_d = 1'b1;
          end
        end else if (uret && in_handler_q) begin
          flush        = 1'b1;
          pc_d         = ret_pc & ALIGN_MASK;
          in_handler_d = 1'b0;
        end else if (redirect) begin
          // A stray uret is treated as absent, so redirect may still apply.
          flush = 1'b1;
          pc_d  = redirect_pc & ALIGN_MASK;
        end else if ((count_q != 2'd2) || pop) begin
          push = 1'b1;
          pc_d = pc_q + PC_W'(4);
        end
      end
      HALT: begin
        flush = 1'b1;
      end
      default: begin
        state_d = HALT;
        flush   = 1'b1;
      end
    endcase
  end

  // Occupancy after this cycle's push/pop/flush.
  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = 2'd0;
    else if (push && !pop)
      count_d = count_q + 2'd1;
    else if (pop && !push)
      count_d = count_q - 2'd1;
  end

  // State, PC and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      in_handler_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      in_handler_q <= in_handler_d;
      fault_q      <= fault_d;
    end
  end

  // Queue storage: shift on pop, then write the pushed word (later write wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else begin
      if (pop) begin
        q_pc[0]   <= q_pc[1];
        q_inst[0] <= q_inst[1];
      end
      if (push) begin
        q_pc[push_idx]   <= pc_q;
        q_inst[push_idx] <= im_instr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. ROM model returns {16'hC0DE, im_pc}.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] im_pc;
  logic [31:0] im_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        trap;
  logic [15:0] trap_vec;
  logic        uret;
  logic [15:0] ret_pc;
  logic        halt;
  logic        in_handler;
  logic        halted;
  logic        fault;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign im_instr = {16'hC0DE, im_pc};

  fetch_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .im_pc(im_pc), .im_instr(im_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .trap(trap), .trap_vec(trap_vec), .uret(uret), .ret_pc(ret_pc),
    .halt(halt), .in_handler(in_handler), .halted(halted), .fault(fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset over one edge, then release 1 ns after it.
  task automatic do_reset();
    rst_n = 1'b0; out_ready = 1'b0;
    redirect = 1'b0; trap = 1'b0; uret = 1'b0; halt = 1'b0;
    redirect_pc = '0; trap_vec = 16'h0100; ret_pc = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_pc !== 16'h0000) $display("FAIL reset_out_pc: got %h expected 0000", out_pc); else pass_cnt++;
    total_cnt++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h expected 0", out_instr); else pass_cnt++;
    total_cnt++; if (im_pc !== 16'h0000) $display("FAIL reset_im_pc: got %h expected 0000", im_pc); else pass_cnt++;
    total_cnt++; if ({in_handler, halted, fault} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {in_handler, halted, fault}); else pass_cnt++;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc;
    do_reset();
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_pc = 16'(4 * i);
      total_cnt++; if (out_valid !== 1'b1 || out_pc !== exp_pc) $display("FAIL seq_pc[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, exp_pc); else pass_cnt++;
      total_cnt++; if (out_instr !== {16'hC0DE, exp_pc}) $display("FAIL seq_instr[%0d]: got %h expected %h", i, out_instr, {16'hC0DE, exp_pc}); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick();
    total_cnt++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) $display("FAIL bp_first: got v=%b pc=%h expected v=1 pc=0000", out_valid, out_pc); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      tick();
      total_cnt++; if (im_pc !== 16'h0008 || out_pc !== 16'h0000) $display("FAIL bp_hold[%0d]: got im_pc=%h out_pc=%h expected 0008/0000", k, im_pc, out_pc); else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();
    total_cnt++; if (out_pc !== 16'h0004 || out_instr !== 32'hC0DE0004) $display("FAIL bp_second: got pc=%h instr=%h expected 0004/C0DE0004", out_pc, out_instr); else pass_cnt++;
    tick();
    total_cnt++; if (out_pc !== 16'h0008 || out_instr !== 32'hC0DE0008) $display("FAIL bp_third: got pc=%h instr=%h expected 0008/C0DE0008", out_pc, out_instr); else pass_cnt++;
    tick();
    total_cnt++; if (out_pc !== 16'h000C) $display("FAIL bp_fourth: got pc=%h expected 000C", out_pc); else pass_cnt++;
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 16'h0012;
    tick();
    redirect = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || im_pc !== 16'h0010) $display("FAIL redir_flush: got v=%b im_pc=%h expected v=0 im_pc=0010", out_valid, im_pc); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    total_cnt++; if (out_valid !== 1'b1 || out_pc !== 16'h0010 || out_instr !== 32'hC0DE0010) $display("FAIL redir_target: got v=%b pc=%h instr=%h expected 1/0010/C0DE0010", out_valid, out_pc, out_instr); else pass_cnt++;
  endtask

  task automatic test_trap_return();
    trap = 1'b1; trap_vec = 16'h0100;
    tick();
    trap = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_handler !== 1'b1) $display("FAIL trap_take: got v=%b ih=%b expected v=0 ih=1", out_valid, in_handler); else pass_cnt++;
    tick();
    total_cnt++; if (out_pc !== 16'h0100 || out_instr !== 32'hC0DE0100) $display("FAIL trap_vec0: got pc=%h instr=%h expected 0100/C0DE0100", out_pc, out_instr); else pass_cnt++;
    tick();
    total_cnt++; if (out_pc !== 16'h0104 || in_handler !== 1'b1) $display("FAIL trap_vec1: got pc=%h ih=%b expected 0104/1", out_pc, in_handler); else pass_cnt++;
    uret = 1'b1; ret_pc = 16'h0010;
    tick();
    uret = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_handler !== 1'b0) $display("FAIL uret_take: got v=%b ih=%b expected v=0 ih=0", out_valid, in_handler); else pass_cnt++;
    tick();
    total_cnt++; if (out_pc !== 16'h0010 || out_valid !== 1'b1) $display("FAIL uret_target: got v=%b pc=%h expected 1/0010", out_valid, out_pc); else pass_cnt++;
  endtask

  task automatic test_nested_and_simul();
    trap = 1'b1; trap_vec = 16'h0100; redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    trap = 1'b0; redirect = 1'b0;
    tick();
    total_cnt++; if (out_pc !== 16'h0100 || in_handler !== 1'b1) $display("FAIL simul_trap_wins: got pc=%h ih=%b expected 0100/1", out_pc, in_handler); else pass_cnt++;
    trap = 1'b1;
    tick();
    trap = 1'b0;
    total_cnt++; if ({fault, halted, out_valid} !== 3'b110) $display("FAIL nested_fault: got f/h/v=%b expected 110", {fault, halted, out_valid}); else pass_cnt++;
    total_cnt++; if (im_pc !== 16'h0104) $display("FAIL nested_im_pc: got %h expected 0104", im_pc); else pass_cnt++;
    redirect = 1'b1; redirect_pc = 16'h0200; uret = 1'b1; ret_pc = 16'h0300;
    tick();
    tick();
    redirect = 1'b0; uret = 1'b0;
    total_cnt++; if (im_pc !== 16'h0104 || out_valid !== 1'b0 || halted !== 1'b1 || in_handler !== 1'b1) $display("FAIL halt_absorb: got im_pc=%h v=%b h=%b ih=%b expected 0104/0/1/1", im_pc, out_valid, halted, in_handler); else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b1;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    total_cnt++; if ({halted, fault, out_valid} !== 3'b100) $display("FAIL halt_take: got h/f/v=%b expected 100", {halted, fault, out_valid}); else pass_cnt++;
    tick();
    total_cnt++; if (im_pc !== 16'h0004 || out_valid !== 1'b0) $display("FAIL halt_frozen: got im_pc=%h v=%b expected 0004/0", im_pc, out_valid); else pass_cnt++;
  endtask

  task automatic test_stray_uret_wrap();
    do_reset();
    out_ready = 1'b1;
    tick();
    tick();
    uret = 1'b1; ret_pc = 16'h0080;
    tick();
    uret = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || out_pc !== 16'h0008 || in_handler !== 1'b0) $display("FAIL stray_uret: got v=%b pc=%h ih=%b expected 1/0008/0", out_valid, out_pc, in_handler); else pass_cnt++;
    tick();
    total_cnt++; if (out_pc !== 16'h000C) $display("FAIL stray_uret_next: got %h expected 000C", out_pc); else pass_cnt++;
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || im_pc !== 16'hFFFC) $display("FAIL wrap_align: got v=%b im_pc=%h expected 0/FFFC", out_valid, im_pc); else pass_cnt++;
    tick();
    total_cnt++; if (out_pc !== 16'hFFFC || out_instr !== 32'hC0DEFFFC) $display("FAIL wrap_last: got pc=%h instr=%h expected FFFC/C0DEFFFC", out_pc, out_instr); else pass_cnt++;
    tick();
    total_cnt++; if (out_pc !== 16'h0000 || out_instr !== 32'hC0DE0000) $display("FAIL wrap_zero: got pc=%h instr=%h expected 0000/C0DE0000", out_pc, out_instr); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    tick();
    trap = 1'b1; trap_vec = 16'h0100;
    tick();
    trap = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({out_valid, in_handler, halted, fault} !== 4'b0000) $display("FAIL midrst_flags: got v/ih/h/f=%b expected 0000", {out_valid, in_handler, halted, fault}); else pass_cnt++;
    total_cnt++; if (im_pc !== 16'h0000 || out_pc !== 16'h0000 || out_instr !== 32'h0) $display("FAIL midrst_values: got im_pc=%h pc=%h instr=%h expected 0000/0000/0", im_pc, out_pc, out_instr); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    total_cnt++; if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== 32'hC0DE0000) $display("FAIL midrst_restart: got v=%b pc=%h instr=%h expected 1/0000/C0DE0000", out_valid, out_pc, out_instr); else pass_cnt++;
    tick();
    total_cnt++; if (out_pc !== 16'h0004) $display("FAIL midrst_next: got %h expected 0004", out_pc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_trap_return();
    test_nested_and_simul();
    test_halt();
    test_stray_uret_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that sits between the core pipeline and the combinational instruction ROM. It owns the program counter, drives the ROM address, and buffers fetched words in a 2-entry queue toward decode with a valid/ready handshake. It applies control-flow changes from execute: branch/jump redirect, trap entry to the trap vector, `uret` return, and halt.

## Interface
- `PC_W`, 16: PC and ROM address width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `im_pc` out PC_W: ROM byte address. The ROM returns the word at `im_pc>>2` combinationally, in the same cycle.
- `im_instr` in 32: ROM data for `im_pc`.
- `out_valid` out 1: queue head is valid.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_instr` out 32: instruction at the queue head.
- `out_pc` out PC_W: PC of `out_instr`.
- `redirect` in 1: branch/jump taken (one-cycle pulse).
- `redirect_pc` in PC_W: target of the branch/jump.
- `trap` in 1: exception, ecall/ebreak or illegal instruction (pulse).
- `trap_vec` in PC_W: handler address, sourced from the utvec CSR (normally 16'h0100).
- `uret` in 1: return from handler (pulse).
- `ret_pc` in PC_W: return address, sourced from the uepc CSR.
- `halt` in 1: end of program (pulse).
- `in_handler` out 1: a trap has been taken and its `uret` has not yet arrived.
- `halted` out 1: block is in HALT.
- `fault` out 1: sticky; set by a nested trap.

## Operation
- States:
  - RUN: normal fetch.
  - HALT: absorbing. Only `rst_n` leaves HALT.
- Queue: 2 entries of {pc, instr}.
  - `count` is 0..2.
  - `out_valid = (count != 0)`.
  - Head fields are driven directly from storage, with no combinational path from `im_instr`.
- Fetch in RUN, with no control event this cycle:
  - Condition: `count < 2`, or (`count == 2` and `out_valid && out_ready`).
  - Action: push {pc, im_instr} and set pc ← pc + 4.
  - Otherwise pc holds and `im_pc` holds.
- Pop: occurs when `out_valid && out_ready`. Push and pop in the same cycle leave `count` unchanged.
- Control events, at most one applied per cycle. Priority order: `halt` > `trap` > `uret` > `redirect`.
  - `halt` → HALT; queue flushed.
  - `trap`:
    - If `in_handler = 0`: pc ← `trap_vec`, `in_handler` ← 1.
    - If `in_handler = 1` (nested trap): `fault` ← 1 and go to HALT.
  - `uret`:
    - If `in_handler = 1`: pc ← `ret_pc`, `in_handler` ← 0.
    - If `in_handler = 0`: the pulse is ignored entirely, with no flush.
  - `redirect`: pc ← `redirect_pc`.
- Effect of any applied event:
  - The queue is flushed (`count` ← 0).
  - No push occurs that cycle.
  - A pop handshake completing in the same cycle still counts as consumed.
- Address rules:
  - Targets loaded into pc (`redirect_pc`, `trap_vec`, `ret_pc`) have bits [1:0] forced to 0.
  - pc + 4 wraps modulo 2^PC_W (16'hFFFC → 16'h0000).
- In HALT:
  - No pushes; `count` = 0; `im_pc` frozen.
  - All event inputs ignored.

## Timing
- Reset values, applied while `rst_n` = 0 (asynchronous):
  - pc = `RESET_PC`, `count` = 0, state = RUN.
  - `out_valid` = 0, `in_handler` = 0, `halted` = 0, `fault` = 0.
  - `out_instr` = 0, `out_pc` = 0.
- First fetch: first rising edge with `rst_n` = 1 pushes ROM[RESET_PC>>2]. `out_valid` = 1 after that edge.
- Steady-state throughput: 1 instruction/cycle while `out_ready` = 1. Latency ROM→out is 1 cycle.
- Event at edge N:
  - Flush and new pc take effect at edge N.
  - Target word is pushed at edge N+1; `out_valid` = 1 after N+1.
  - Exactly 1 bubble cycle results.
- `halted` and `fault` are asserted after the edge that takes the event.
- Mid-operation reset: `rst_n` low returns all state to reset values immediately, regardless of state or `count`.

## Test plan
- Sequential fetch:
  - Stimulus: ROM[0..4] loaded, `out_ready` = 1.
  - Required: `out_pc` = 0,4,8,12,16 on consecutive cycles, `out_instr` matching ROM, starting one cycle after reset release.
- Backpressure:
  - Stimulus: `out_ready` = 0 for 5 cycles after the first valid, then 1.
  - Required: `count` saturates at 2 with `im_pc` = 8 held; entries pc 0 and pc 4 are delivered in order with no loss or duplicate; pc 8 follows.
- Redirect:
  - Stimulus: `redirect` with `redirect_pc` = 16'h0012 while `count` = 2.
  - Required: queue flushed, one bubble, next `out_pc` = 16'h0010.
- Trap and return:
  - Stimulus: `trap` with `trap_vec` = 16'h0100, then `uret` with `ret_pc` = 16'h0010.
  - Required: `out_pc` = 0x100, 0x104… with `in_handler` = 1; after `uret`, `out_pc` = 0x010 with `in_handler` = 0.
- Nested trap and simultaneous events:
  - Stimulus 1: `trap` while `in_handler` = 1.
    - Required: `fault` = 1, `halted` = 1, `out_valid` = 0, `im_pc` frozen.
  - Stimulus 2: `trap` and `redirect` in the same cycle.
    - Required: the trap target wins.
- Stray `uret`, wrap and reset:
  - Stimulus 1: `uret` with `in_handler` = 0.
    - Required: no flush; sequence unchanged.
  - Stimulus 2: redirect to 16'hFFFC.
    - Required: next `out_pc` values are 16'hFFFC, 16'h0000.
  - Stimulus 3: `rst_n` pulsed low mid-stream.
    - Required: all outputs return to reset values; fetch restarts at `RESET_PC`.
